// File: rtl/display_select_ctrl.sv
// rtl/display_select_ctrl.sv - registered display source selector with alarm hold and key-entry blink
module display_select_ctrl #(
  parameter int DIGIT_W     = 4,
  parameter int NUM_DIGITS  = 4,
  parameter int HOLD_CYCLES = 3,
  parameter int BLINK_DIV   = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] current_time,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] alarm_time,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] key_time,
  input  logic                          show_a,
  input  logic                          show_new_time,
  input  logic                          blink_en,
  output logic [DIGIT_W*NUM_DIGITS-1:0] display_time,
  output logic [1:0]                    display_src
);

  localparam int W   = DIGIT_W * NUM_DIGITS;
  localparam int HCW = $clog2(HOLD_CYCLES + 1);
  localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [HCW-1:0] HOLD_LOAD  = HCW'(HOLD_CYCLES);
  localparam logic [HCW-1:0] HOLD_ONE   = HCW'(1);
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_DIV - 1);
  localparam logic [BCW-1:0] BLINK_ONE  = BCW'(1);
  localparam logic [W-1:0]   BLANK      = '1;

  typedef enum logic [1:0] {
    ST_CUR = 2'b00,
    ST_ALM = 2'b01,
    ST_KEY = 2'b10
  } state_t;

  state_t         state;
  logic [HCW-1:0] hold_cnt;
  logic [BCW-1:0] blink_cnt;
  logic           blink_ph;

  // Outputs are loaded from the same branch that picks the next state, so the
  // display always reflects the state being entered and the data sampled now.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= ST_CUR;
      hold_cnt     <= '0;
      blink_cnt    <= '0;
      blink_ph     <= 1'b0;
      display_time <= '0;
      display_src  <= 2'b00;
    end else if (show_new_time) begin
      state       <= ST_KEY;
      hold_cnt    <= '0;
      display_src <= 2'b10;
      if (state != ST_KEY) begin
        blink_cnt    <= '0;
        blink_ph     <= 1'b0;
        display_time <= key_time;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt    <= '0;
        blink_ph     <= ~blink_ph;
        display_time <= (blink_en && !blink_ph) ? BLANK : key_time;
      end else begin
        blink_cnt    <= blink_cnt + BLINK_ONE;
        display_time <= (blink_en && blink_ph) ? BLANK : key_time;
      end
    end else begin
      blink_cnt <= '0;
      blink_ph  <= 1'b0;
      if (show_a) begin
        state        <= ST_ALM;
        hold_cnt     <= HOLD_LOAD;
        display_time <= alarm_time;
        display_src  <= 2'b01;
      end else if (state == ST_ALM && hold_cnt > HOLD_ONE) begin
        hold_cnt     <= hold_cnt - HOLD_ONE;
        display_time <= alarm_time;
        display_src  <= 2'b01;
      end else begin
        state        <= ST_CUR;
        hold_cnt     <= '0;
        display_time <= current_time;
        display_src  <= 2'b00;
      end
    end
  end

endmodule
